// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for a 5-stage pipeline. Drives the enable and
// bubble-insert (flush) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. It sequences load-use stalls, taken-branch squashes, multi-cycle
// EX operations and memory wait states. All control outputs are combinational
// from the current state and the inputs, so they act in the same cycle.
//
// Optional feature: define PIPE_MEM_TIMEOUT_EN to add a memory-stall watchdog
// that raises a sticky Mem_Timeout. Without the macro, Mem_Timeout is tied to 0.
//
// Ports:
//   Clk, Rst            clock (rising edge), synchronous active-high reset
//   IDEX_MemRead/Rd     the instruction in EX is a load / its destination
//   IFID_Rs/Rt/UsesRt   source registers of the instruction in ID
//   EX_BranchTaken      the branch in EX resolved taken
//   EX_McStart          the instruction in EX is a multi-cycle op
//   Mem_Req/Mem_Ready   MEM stage access request / completion
//   *_En                pipeline register enables
//   *_Flush             bubble insert, ORed externally into the register reset
//   Mc_Busy             a multi-cycle op is in progress
//   Mem_Timeout         sticky watchdog error
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int RW     = 5,
  parameter int MC_LAT = 4,
  parameter int CW     = 3,
  parameter int TW     = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          IDEX_MemRead,
  input  logic [RW-1:0] IDEX_Rd,
  input  logic [RW-1:0] IFID_Rs,
  input  logic [RW-1:0] IFID_Rt,
  input  logic          IFID_UsesRt,
  input  logic          EX_BranchTaken,
  input  logic          EX_McStart,
  input  logic          Mem_Req,
  input  logic          Mem_Ready,
  output logic          PC_En,
  output logic          IFID_En,
  output logic          IDEX_En,
  output logic          EXMEM_En,
  output logic          MEMWB_En,
  output logic          IFID_Flush,
  output logic          IDEX_Flush,
  output logic          EXMEM_Flush,
  output logic          MEMWB_Flush,
  output logic          Mc_Busy,
  output logic          Mem_Timeout
);

  // The counter is loaded with MC_LAT-2: the start cycle and the completion
  // cycle together account for two of the MC_LAT cycles of EX occupancy.
  localparam logic [CW-1:0] MC_LOAD = CW'(MC_LAT - 2);

  // Reject parameter sets the counters cannot represent.
  if (MC_LAT < 2 || (2 ** CW) <= (MC_LAT - 2) || TW < 1) begin : g_bad_params
    $error("pipe_hazard_ctrl: illegal MC_LAT/CW/TW combination");
  end

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          memstall;
  logic          loaduse;

  assign memstall = Mem_Req & ~Mem_Ready;
  assign loaduse  = IDEX_MemRead & (IDEX_Rd != '0) &
                    ((IDEX_Rd == IFID_Rs) | (IFID_UsesRt & (IDEX_Rd == IFID_Rt)));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    PC_En       = 1'b1;
    IFID_En     = 1'b1;
    IDEX_En     = 1'b1;
    EXMEM_En    = 1'b1;
    MEMWB_En    = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    MEMWB_Flush = 1'b0;

    if (memstall) begin
      // Freeze everything and let a bubble drain into WB. The multi-cycle
      // countdown keeps running so the stall overlaps the EX latency.
      PC_En       = 1'b0;
      IFID_En     = 1'b0;
      IDEX_En     = 1'b0;
      EXMEM_En    = 1'b0;
      MEMWB_En    = 1'b0;
      MEMWB_Flush = 1'b1;
      if (state_reg == MC_BUSY && cnt_reg != '0) begin
        cnt_next = cnt_reg - 1'b1;
      end
    end else if (state_reg == MC_BUSY && cnt_reg != '0) begin
      PC_En       = 1'b0;
      IFID_En     = 1'b0;
      IDEX_En     = 1'b0;
      EXMEM_Flush = 1'b1;
      cnt_next    = cnt_reg - 1'b1;
    end else begin
      // RUN, or the completion cycle of MC_BUSY (which never restarts an op).
      if (EX_BranchTaken) begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end else if (state_reg == RUN && EX_McStart) begin
        PC_En       = 1'b0;
        IFID_En     = 1'b0;
        IDEX_En     = 1'b0;
        EXMEM_Flush = 1'b1;
        cnt_next    = MC_LOAD;
        state_next  = MC_BUSY;
      end else if (loaduse) begin
        PC_En      = 1'b0;
        IFID_En    = 1'b0;
        IDEX_Flush = 1'b1;
      end
      if (state_reg == MC_BUSY) begin
        state_next = RUN;
      end
    end

    if (Rst) begin
      PC_En       = 1'b0;
      IFID_En     = 1'b0;
      IDEX_En     = 1'b0;
      EXMEM_En    = 1'b0;
      MEMWB_En    = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
      MEMWB_Flush = 1'b1;
    end
  end

  assign Mc_Busy = (state_reg == MC_BUSY) & ~Rst;

`ifdef PIPE_MEM_TIMEOUT_EN
  localparam logic [TW-1:0] WD_MAX = '1;

  logic [TW-1:0] wd_reg;
  logic          timeout_reg;

  // Counts consecutive memstall cycles; the error flag is sticky until reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else if (memstall) begin
      if (wd_reg != WD_MAX) begin
        wd_reg <= wd_reg + 1'b1;
      end
      if (wd_reg == WD_MAX - 1'b1) begin
        timeout_reg <= 1'b1;
      end
    end else begin
      wd_reg <= '0;
    end
  end

  assign Mem_Timeout = timeout_reg & ~Rst;
`else
  assign Mem_Timeout = 1'b0;
`endif

endmodule
